// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, buffers words for decode.
// Optional FETCH_PERF_EN adds redirect_count and squash_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] squash_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SQUASH
  } state_t;

  state_t state, state_nxt;

  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_pc;
  logic [31:0] mem_pc  [FIFO_DEPTH];
  logic [31:0] mem_ins [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0] last_pc, last_ins;
  logic        accept, redirect, push;
  logic [31:0] br_off, target;

  // Outputs hold the last accepted word while the FIFO is empty
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_ins[rd_ptr] : last_ins;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]  : last_pc;
  assign pc_plus4    = instr_pc + 32'd4;
  assign imem_addr   = fetch_pc;

  assign accept   = instr_valid & instr_ready;
  assign redirect = accept & (pc_src | jump);
  assign br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign target   = jump ? {pc_plus4[31:28], jump_target, 2'b00}
                         : pc_plus4 + br_off;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    imem_req     = 1'b0;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n && !redirect && count < DEPTH_C) begin
          imem_req     = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = !redirect;
          state_nxt = IDLE;
        end else if (redirect) begin
          state_nxt = SQUASH;
        end
      end
      SQUASH: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) fetch_pc_nxt = target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (imem_req) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_pc  <= '0;
      last_ins <= '0;
    end else begin
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + AW'(1);
        if (accept) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(accept);
      end
      if (accept) begin
        last_pc  <= instr_pc;
        last_ins <= instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]  <= req_pc;
      mem_ins[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] drop_n;

  // Flushed entries exclude the accepted head; plus any discarded response
  always_comb begin
    drop_n = '0;
    if (redirect) drop_n = 32'(count) - 32'd1;
    if (imem_rvalid && ((state == WAIT && redirect) || state == SQUASH))
      drop_n = drop_n + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= '0;
      squash_count   <= '0;
    end else begin
      if (redirect) redirect_count <= redirect_count + 32'd1;
      squash_count <= squash_count + drop_n;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus program-order reference
// of the PC stream decode must see, with directed and random phases.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic        pc_src = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] branch_imm = '0;
  logic [25:0] jump_target = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] redirect_count, squash_count;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .pc_src(pc_src), .jump(jump),
    .branch_imm(branch_imm), .jump_target(jump_target)
`ifdef FETCH_PERF_EN
    , .redirect_count(redirect_count), .squash_count(squash_count)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;

  // reference state
  logic [31:0] exp_pc, exp_fetch, maddr, last_acc_pc, last_req_addr;
  int entries, cnt, nreq, nacc, drops;
  bit pending, stale, inj_rv, arm, hit, pend_hit, rnd_br;
  int rdy_mode, lat_lo, lat_hi;
  logic [31:0] dir_pc;
  bit dir_src, dir_jump;
  logic [15:0] dir_imm;
  logic [25:0] dir_jt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    entries = 0; pending = 0; stale = 0; cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_rvalid = 0; instr_ready = 0;
    pc_src = 0; jump = 0;
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_pc4", pc_plus4, 4);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic step();
    bit rv, acc, redir, exp_req, hit_now;
    logic [31:0] tgt;
    rv = pending && cnt == 0;
    hit_now = 0;
    tgt = '0;
    imem_rvalid = rv || inj_rv;
    imem_rdata  = rv ? word_at(maddr) : 32'hDEAD_BEEF;
    instr_ready = (rdy_mode == 1) ? 1'b1 :
                  (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    pc_src = rnd_br && ($urandom_range(0, 5) == 0);
    jump   = rnd_br && ($urandom_range(0, 7) == 0);
    branch_imm  = 16'($urandom);
    jump_target = 26'($urandom);
    #1;
    if (arm && instr_valid && instr_ready && instr_pc == dir_pc) begin
      pc_src = dir_src; jump = dir_jump;
      branch_imm = dir_imm; jump_target = dir_jt;
      arm = 0; hit = 1; hit_now = 1;
    end
    #1;
    chk("valid", instr_valid, 32'(entries != 0));
    acc = instr_valid && instr_ready;
    if (acc) begin
      chk("head_pc", instr_pc, exp_pc);
      chk("head_instr", instr, word_at(exp_pc));
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      last_acc_pc = instr_pc;
      nacc++;
    end
    redir = acc && (pc_src || jump);
    if (redir) begin
      if (jump)
        tgt = ((exp_pc + 32'd4) & 32'hF000_0000) + 32'(jump_target) * 32'd4;
      else
        tgt = exp_pc + 32'd4 + 32'($signed(branch_imm)) * 32'd4;
    end
    exp_req = !pending && entries < FIFO_DEPTH && !redir;
    chk("req", 32'(imem_req), 32'(exp_req));
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      last_req_addr = imem_addr;
      nreq++;
    end
    if (acc) exp_pc = redir ? tgt : exp_pc + 32'd4;
    entries = entries + ((rv && !stale) ? 1 : 0) - (acc ? 1 : 0);
    if (hit_now) pend_hit = pending && !rv;
    if (redir) begin
      entries = 0;
      exp_fetch = tgt;
      if (pending && !rv) stale = 1;
    end
    if (rv) begin
      if (stale || redir) drops++;
      pending = 0; stale = 0;
    end
    if (imem_req) begin
      pending = 1;
      cnt = $urandom_range(lat_lo, lat_hi) - 1;
      maddr = imem_addr;
    end else if (pending) begin
      cnt--;
    end
    inj_rv = 0;
    @(negedge clk);
  endtask

  task automatic run_to_acc();
    int n0 = nacc;
    for (int i = 0; i < 40 && nacc == n0; i++) step();
  endtask

  task automatic arm_dir(input logic [31:0] pc, input bit s, input bit j,
                         input logic [15:0] imm, input logic [25:0] jt);
    dir_pc = pc; dir_src = s; dir_jump = j; dir_imm = imm; dir_jt = jt;
    hit = 0; arm = 1;
  endtask

  initial begin
    int n0, d0;
    logic [31:0] sq_tgt;
    nreq = 0; nacc = 0; drops = 0; inj_rv = 0; arm = 0; hit = 0;
    pend_hit = 0; rnd_br = 0; rdy_mode = 0; lat_lo = 1; lat_hi = 1;
    last_acc_pc = '0; last_req_addr = '0;
    model_reset();
    do_reset();

    // decode stalled: only FIFO_DEPTH fetches go out
    for (int i = 0; i < 10; i++) step();
    chk("stall_reqs", nreq, FIFO_DEPTH);
    rdy_mode = 1;
    n0 = nacc;
    for (int i = 0; i < 8; i++) step();
    chk("resume_pops", 32'(nacc - n0 >= 3), 1);

    // taken branch at 0x10 back to 0x4
    do_reset();
    arm_dir(32'h10, 1, 0, 16'hFFFC, '0);
    for (int i = 0; i < 60 && !hit; i++) step();
    chk("br_hit", 32'(hit), 1);
    run_to_acc();
    chk("br_next", last_acc_pc, 32'h4);

    // jump out to 0x0040_0000, then jump beats branch there
    arm_dir(32'h20, 0, 1, 16'h0, 26'h010_0000);
    for (int i = 0; i < 60 && !hit; i++) step();
    chk("jmp1_hit", 32'(hit), 1);
    arm_dir(32'h0040_0000, 1, 1, 16'hFFFC, 26'h10);
    run_to_acc();
    chk("jmp1_next", last_acc_pc, 32'h0040_0000);
    for (int i = 0; i < 60 && !hit; i++) step();
    chk("jmp2_hit", 32'(hit), 1);
    run_to_acc();
    chk("jmp2_next", last_acc_pc, 32'h40);

    // redirect with a request still in flight
    lat_lo = 3; lat_hi = 3; rdy_mode = 0;
    for (int i = 0; i < 30 && !(entries >= 1 && pending); i++) step();
    sq_tgt = exp_pc + 32'd4 + 32'h40;
    d0 = drops;
    arm_dir(exp_pc, 1, 0, 16'h0010, '0);
    rdy_mode = 1;
    for (int i = 0; i < 5 && !hit; i++) step();
    chk("sq_hit", 32'(hit), 1);
    chk("sq_pend", 32'(pend_hit), 1);
    run_to_acc();
    chk("sq_next", last_acc_pc, sq_tgt);
    chk("sq_drop", drops - d0, 1);

    // reset while waiting, stale response afterwards
    for (int i = 0; i < 10 && !pending; i++) step();
    chk("rw_pend", 32'(pending), 1);
    do_reset();
    n0 = nreq;
    inj_rv = 1;
    step();
    chk("rw_nreq", nreq - n0, 1);
    chk("rw_addr", last_req_addr, RESET_PC);
    run_to_acc();
    chk("rw_first", last_acc_pc, RESET_PC);

    // random traffic
    rdy_mode = 2; lat_lo = 1; lat_hi = 4; rnd_br = 1;
    for (int i = 0; i < 3000; i++) step();
    chk("rand_progress", 32'(nacc > 500), 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
